// File: rtl/multiphase_pulse_gen_if.sv
// Signal bundle between the phase sequencer and its controller:
// mode requests and phase length in, phase pulses and frame status out.
interface multiphase_pulse_gen_if #(
    parameter int NPH = 4,
    parameter int CW  = 4,
    parameter int FCW = 16
);
    localparam int IW = (NPH > 1) ? $clog2(NPH) : 1;

    logic           FORCE;
    logic           HOLD;
    logic [CW-1:0]  PHASE_LEN;
    logic [NPH-1:0] PH;
    logic           FRAME;
    logic [IW-1:0]  PHASE_IDX;
    logic [FCW-1:0] FRAME_CNT;
    logic           BUSY;

    // Controller side: issues requests, observes pulses.
    modport master (
        output FORCE, HOLD, PHASE_LEN,
        input  PH, FRAME, PHASE_IDX, FRAME_CNT, BUSY
    );

    // Generator side: takes requests, drives pulses.
    modport slave (
        input  FORCE, HOLD, PHASE_LEN,
        output PH, FRAME, PHASE_IDX, FRAME_CNT, BUSY
    );
endinterface

// File: rtl/multiphase_pulse_gen.sv
// N-phase non-overlapping pulse generator. Each phase is held for
// len_q+1 cycles; force/hold mode changes and new phase lengths are only
// taken at frame boundaries so a running pulse is never cut short.
module multiphase_pulse_gen #(
    parameter int NPH = 4,
    parameter int CW  = 4,
    parameter int FCW = 16
) (
    input  logic                         CLK,
    input  logic                         RST,
    multiphase_pulse_gen_if.slave        bus
);
    localparam int IW = (NPH > 1) ? $clog2(NPH) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NPH - 1);

    typedef enum logic [1:0] {
        HOLDST  = 2'd0,
        FORCEST = 2'd1,
        RUN     = 2'd2
    } state_t;

    state_t         state_r, state_s;
    logic [IW-1:0]  idx_r, idx_s;
    logic [CW-1:0]  cnt_r, cnt_s;
    logic [CW-1:0]  len_r, len_s;
    logic [FCW-1:0] fcnt_r, fcnt_s;
    logic [NPH-1:0] ph_r, ph_s;
    logic           frame_r, frame_s;
    logic [IW-1:0]  pidx_r, pidx_s;
    logic           busy_r, busy_s;
    logic           decide_s;

    // Next-state sequencing: advance within a frame, or take the current request.
    always_comb begin
        state_s  = state_r;
        idx_s    = idx_r;
        cnt_s    = cnt_r;
        len_s    = len_r;
        fcnt_s   = fcnt_r;
        frame_s  = 1'b0;
        decide_s = 1'b0;
        case (state_r)
            HOLDST, FORCEST: begin
                decide_s = 1'b1;
            end
            RUN: begin
                if (cnt_r < len_r) begin
                    cnt_s = cnt_r + CW'(1);
                end else if (idx_r < LAST_IDX) begin
                    idx_s = idx_r + IW'(1);
                    cnt_s = {CW{1'b0}};
                end else begin
                    decide_s = 1'b1;
                end
            end
            default: begin
                state_s = HOLDST;
            end
        endcase
        if (decide_s) begin
            if (bus.FORCE) begin
                state_s = FORCEST;
            end else if (bus.HOLD) begin
                state_s = HOLDST;
            end else begin
                state_s = RUN;
                idx_s   = {IW{1'b0}};
                cnt_s   = {CW{1'b0}};
                len_s   = bus.PHASE_LEN;
                fcnt_s  = fcnt_r + FCW'(1);
                frame_s = 1'b1;
            end
        end else begin
            frame_s = 1'b0;
        end
    end

    // Output decode from the next state so outputs register on the same edge.
    always_comb begin
        ph_s   = {NPH{1'b0}};
        pidx_s = {IW{1'b0}};
        busy_s = 1'b0;
        case (state_s)
            RUN: begin
                ph_s   = NPH'(1) << idx_s;
                pidx_s = idx_s;
                busy_s = 1'b1;
            end
            FORCEST: begin
                ph_s = {NPH{1'b1}};
            end
            HOLDST: begin
                ph_s = {NPH{1'b0}};
            end
            default: begin
                ph_s = {NPH{1'b0}};
            end
        endcase
    end

    // State and output registers with immediate clear on reset.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_r <= HOLDST;
            idx_r   <= {IW{1'b0}};
            cnt_r   <= {CW{1'b0}};
            len_r   <= {CW{1'b0}};
            fcnt_r  <= {FCW{1'b0}};
            ph_r    <= {NPH{1'b0}};
            frame_r <= 1'b0;
            pidx_r  <= {IW{1'b0}};
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            idx_r   <= idx_s;
            cnt_r   <= cnt_s;
            len_r   <= len_s;
            fcnt_r  <= fcnt_s;
            ph_r    <= ph_s;
            frame_r <= frame_s;
            pidx_r  <= pidx_s;
            busy_r  <= busy_s;
        end
    end

    assign bus.PH        = ph_r;
    assign bus.FRAME     = frame_r;
    assign bus.PHASE_IDX = pidx_r;
    assign bus.FRAME_CNT = fcnt_r;
    assign bus.BUSY      = busy_r;
endmodule
